// File: rtl/cpu_mem_wb_pkg.sv
// Shared CPU definitions: execute-stage result record, memory-op kind and
// memory/write-back FSM state encodings.
package lib_cpu;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 30;
    localparam int EX_RD_W = 4;

    typedef struct packed {
        logic [31:0]         pc;
        logic [EX_RD_W-1:0]  rd;
        logic [DATA_W-1:0]   x_rd;
        logic [ADDR_W-1:0]   addr_4byte;
        logic [DATA_W-1:0]   mem_val;
        logic                intr_en;
    } execute_t;

    typedef enum logic [1:0] {
        KIND_PLAIN = 2'b00,
        KIND_LOAD  = 2'b01,
        KIND_STORE = 2'b10
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MEM  = 2'b01,
        ST_WB   = 2'b10
    } state_e;

    // The reserved encoding 2'b11 behaves exactly like a plain op.
    function automatic kind_e norm_kind(input logic [1:0] k);
        case (k)
            2'b01:   return KIND_LOAD;
            2'b10:   return KIND_STORE;
            default: return KIND_PLAIN;
        endcase
    endfunction

endpackage

// File: rtl/cpu_mem_wb_if.sv
// Data-bus interface between the memory/write-back stage (master) and memory (slave).
interface cpu_mem_wb_if;
    import lib_cpu::*;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/cpu_mem_wb.sv
// Memory-access and write-back stage: one transaction at a time, IDLE -> [MEM] -> WB.
// Optional bus timeout is enabled by defining CPU_MEM_TIMEOUT_EN.
module cpu_mem_wb
    import lib_cpu::*;
#(
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd255,
    parameter int         RD_W           = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ex_valid,
    output logic               ex_ready,
    input  execute_t           ex,
    input  logic [1:0]         ex_kind,
    cpu_mem_wb_if.master       bus,
    output logic               rf_we,
    output logic [RD_W-1:0]    rf_waddr,
    output logic [DATA_W-1:0]  rf_wdata,
    output logic               pc_valid,
    output logic [31:0]        pc_next,
    output logic               err
);

    state_e              state_q, state_d;
    kind_e               kind_p1;
    logic [31:0]         pc_p1;
    logic [EX_RD_W-1:0]  rd_p1;
    logic [DATA_W-1:0]   xrd_p1;
    logic [ADDR_W-1:0]   addr_p1;
    logic [DATA_W-1:0]   wdata_p1;
    logic [DATA_W-1:0]   rdata_p1;
    logic                to_p1;
    logic                timeout_hit;
    logic                unused_intr;

    assign unused_intr = ex.intr_en;

`ifdef CPU_MEM_TIMEOUT_EN
    logic [7:0] cnt_p1;

    assign timeout_hit = (state_q == ST_MEM) && !bus.mem_ack &&
                         ((cnt_p1 + 8'd1) == TIMEOUT_CYCLES);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_p1 <= '0;
            to_p1  <= 1'b0;
        end else begin
            if (state_q == ST_IDLE) begin
                cnt_p1 <= '0;
                to_p1  <= 1'b0;
            end else if (state_q == ST_MEM && !bus.mem_ack) begin
                cnt_p1 <= cnt_p1 + 8'd1;
            end
            if (timeout_hit) to_p1 <= 1'b1;
        end
    end
`else
    localparam logic [7:0] unused_timeout = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
    assign to_p1       = 1'b0;
`endif

    // Capture stage: execute result latched at the handshake, load data at the ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            kind_p1  <= KIND_PLAIN;
            pc_p1    <= '0;
            rd_p1    <= '0;
            xrd_p1   <= '0;
            addr_p1  <= '0;
            wdata_p1 <= '0;
            rdata_p1 <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && ex_valid) begin
                kind_p1  <= norm_kind(ex_kind);
                pc_p1    <= ex.pc;
                rd_p1    <= ex.rd;
                xrd_p1   <= ex.x_rd;
                addr_p1  <= ex.addr_4byte;
                wdata_p1 <= ex.mem_val;
            end
            if (state_q == ST_MEM && bus.mem_ack && kind_p1 == KIND_LOAD)
                rdata_p1 <= bus.mem_rdata;
        end
    end

    // Output stage: everything below depends on registered state only.
    always_comb begin
        state_d       = state_q;
        ex_ready      = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = addr_p1;
        bus.mem_wdata = wdata_p1;
        rf_we         = 1'b0;
        rf_waddr      = RD_W'(rd_p1);
        rf_wdata      = (kind_p1 == KIND_LOAD) ? rdata_p1 : xrd_p1;
        pc_valid      = 1'b0;
        pc_next       = pc_p1;
        err           = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ex_ready = 1'b1;
                if (ex_valid)
                    state_d = (norm_kind(ex_kind) == KIND_PLAIN) ? ST_WB : ST_MEM;
            end
            ST_MEM: begin
                bus.mem_req = 1'b1;
                bus.mem_we  = (kind_p1 == KIND_STORE);
                if (bus.mem_ack || timeout_hit) state_d = ST_WB;
            end
            ST_WB: begin
                pc_valid = 1'b1;
                rf_we    = (kind_p1 != KIND_STORE) && (rd_p1 != '0) && !to_p1;
                err      = to_p1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cpu_mem_wb.sv
// Randomised bench for cpu_mem_wb with a transaction-level reference model.
// Define CPU_MEM_TIMEOUT_EN to exercise the bus-timeout build.
module tb_cpu_mem_wb;
    import lib_cpu::*;

`ifdef CPU_MEM_TIMEOUT_EN
    localparam logic [7:0] TO_CYC = 8'd4;
`else
    localparam logic [7:0] TO_CYC = 8'd255;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    execute_t    ex;
    logic [1:0]  ex_kind;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        pc_valid;
    logic [31:0] pc_next;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    cpu_mem_wb_if bus();

    cpu_mem_wb #(.TIMEOUT_CYCLES(TO_CYC), .RD_W(4)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex(ex), .ex_kind(ex_kind), .bus(bus), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pc_valid(pc_valid),
        .pc_next(pc_next), .err(err)
    );

    always #5 clk = ~clk;

    // Control outputs packed as {ex_ready, mem_req, mem_we, rf_we, pc_valid, err}.
    function automatic logic [5:0] ctl();
        return {ex_ready, bus.mem_req, bus.mem_we, rf_we, pc_valid, err};
    endfunction

    function automatic execute_t rand_ex();
        execute_t e;
        e.pc         = $urandom;
        e.rd         = 4'($urandom_range(0, 15));
        e.x_rd       = $urandom;
        e.addr_4byte = 30'($urandom);
        e.mem_val    = $urandom;
        e.intr_en    = 1'($urandom_range(0, 1));
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; ex_valid = 1'b1; ex = rand_ex(); ex_kind = 2'b01;
        bus.mem_ack = 1'b1; bus.mem_rdata = '0;
        tick(); tick();
        n_checks++;
        if (ctl() !== 6'b100000) begin
            n_fail++; $display("FAIL reset_ctl got=%b exp=%b", ctl(), 6'b100000);
        end
        n_checks++;
        if ({bus.mem_addr, bus.mem_wdata, rf_waddr, rf_wdata, pc_next} !== '0) begin
            n_fail++; $display("FAIL reset_data got=%h/%h/%h/%h/%h exp=0",
                bus.mem_addr, bus.mem_wdata, rf_waddr, rf_wdata, pc_next);
        end
        reset = 1'b0; ex_valid = 1'b0; bus.mem_ack = 1'b0;
        tick();
        n_checks++;
        if (ctl() !== 6'b100000) begin
            n_fail++; $display("FAIL reset_idle got=%b exp=%b", ctl(), 6'b100000);
        end
    endtask

    task automatic test_plain();
        execute_t e = rand_ex();
        e.rd = 4'd3; e.x_rd = 32'h1234_5678;
        ex = e; ex_kind = 2'b00; ex_valid = 1'b1;
        tick();
        ex_valid = 1'b0;
        n_checks++;
        if (ctl() !== 6'b000110) begin
            n_fail++; $display("FAIL plain_ctl got=%b exp=%b", ctl(), 6'b000110);
        end
        n_checks++;
        if ({rf_waddr, rf_wdata, pc_next} !== {4'd3, 32'h1234_5678, e.pc}) begin
            n_fail++; $display("FAIL plain_data got=%h/%h/%h exp=3/12345678/%h",
                rf_waddr, rf_wdata, pc_next, e.pc);
        end
        tick();
        n_checks++;
        if (ctl() !== 6'b100000) begin
            n_fail++; $display("FAIL plain_back_idle got=%b exp=%b", ctl(), 6'b100000);
        end
    endtask

    task automatic test_load();
        execute_t e = rand_ex();
        e.rd = 4'd5; e.addr_4byte = 30'h10;
        ex = e; ex_kind = 2'b01; ex_valid = 1'b1;
        tick();
        ex_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            n_checks++;
            if (ctl() !== 6'b010000 || bus.mem_addr !== 30'h10) begin
                n_fail++; $display("FAIL load_mem_c%0d got=%b/%h exp=010000/10", c, ctl(), bus.mem_addr);
            end
            if (c == 3) begin bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF; end
            tick();
        end
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0BAD_0BAD;
        n_checks++;
        if (ctl() !== 6'b000110 || rf_wdata !== 32'hDEAD_BEEF || rf_waddr !== 4'd5) begin
            n_fail++; $display("FAIL load_wb got=%b/%h/%h exp=000110/deadbeef/5", ctl(), rf_wdata, rf_waddr);
        end
        tick();
    endtask

    task automatic test_store();
        execute_t e = rand_ex();
        e.rd = 4'd7; e.mem_val = 32'hA5A5_A5A5;
        ex = e; ex_kind = 2'b10; ex_valid = 1'b1;
        tick();
        ex_valid = 1'b0;
        n_checks++;
        if (ctl() !== 6'b011000 || bus.mem_wdata !== 32'hA5A5_A5A5 || bus.mem_addr !== e.addr_4byte) begin
            n_fail++; $display("FAIL store_mem got=%b/%h/%h exp=011000/a5a5a5a5/%h",
                ctl(), bus.mem_wdata, bus.mem_addr, e.addr_4byte);
        end
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        n_checks++;
        if (ctl() !== 6'b000010 || pc_next !== e.pc) begin
            n_fail++; $display("FAIL store_wb got=%b/%h exp=000010/%h", ctl(), pc_next, e.pc);
        end
        tick();
    endtask

    task automatic test_x0();
        execute_t e = rand_ex();
        e.rd = 4'd0; e.x_rd = 32'hFFFF_FFFF;
        ex = e; ex_kind = 2'b00; ex_valid = 1'b1;
        tick();
        ex_valid = 1'b0;
        n_checks++;
        if (ctl() !== 6'b000010) begin
            n_fail++; $display("FAIL x0_wb got=%b exp=%b", ctl(), 6'b000010);
        end
        tick();
    endtask

    task automatic test_reset_mid_mem();
        ex = rand_ex(); ex_kind = 2'b01; ex_valid = 1'b1;
        tick();
        ex_valid = 1'b0;
        tick();
        n_checks++;
        if (ctl() !== 6'b010000) begin
            n_fail++; $display("FAIL rstmem_mem2 got=%b exp=%b", ctl(), 6'b010000);
        end
        reset = 1'b1; bus.mem_ack = 1'b1;
        tick();
        reset = 1'b0; bus.mem_ack = 1'b0;
        n_checks++;
        if (ctl() !== 6'b100000) begin
            n_fail++; $display("FAIL rstmem_after got=%b exp=%b", ctl(), 6'b100000);
        end
        tick();
        n_checks++;
        if (ctl() !== 6'b100000) begin
            n_fail++; $display("FAIL rstmem_nowb got=%b exp=%b", ctl(), 6'b100000);
        end
    endtask

    task automatic test_ignore_ack();
        ex_valid = 1'b0; bus.mem_ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (ctl() !== 6'b100000) begin
                n_fail++; $display("FAIL idle_ack_%0d got=%b exp=%b", i, ctl(), 6'b100000);
            end
        end
        bus.mem_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        execute_t ops[6];
        for (int i = 0; i < 6; i++) ops[i] = rand_ex();
        ex_kind = 2'b00; ex_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ex = ops[i];
            tick();
            // Offer the next op during WB; it must wait for IDLE.
            ex = ops[(i + 1) % 6];
            n_checks++;
            if (ctl() !== {3'b000, ops[i].rd != 4'd0, 2'b10} || pc_next !== ops[i].pc ||
                rf_wdata !== ops[i].x_rd || rf_waddr !== ops[i].rd) begin
                n_fail++; $display("FAIL b2b_wb%0d got=%b/%h/%h exp_pc=%h exp_d=%h",
                    i, ctl(), pc_next, rf_wdata, ops[i].pc, ops[i].x_rd);
            end
            tick();
            n_checks++;
            if (ctl() !== 6'b100000) begin
                n_fail++; $display("FAIL b2b_idle%0d got=%b exp=%b", i, ctl(), 6'b100000);
            end
        end
        ex_valid = 1'b0;
    endtask

    task automatic test_timeout();
        ex = rand_ex(); ex_kind = 2'b01; ex_valid = 1'b1; bus.mem_ack = 1'b0;
        tick();
        ex_valid = 1'b0;
`ifdef CPU_MEM_TIMEOUT_EN
        for (int c = 1; c <= 4; c++) begin
            n_checks++;
            if (ctl() !== 6'b010000) begin
                n_fail++; $display("FAIL timeout_mem_c%0d got=%b exp=%b", c, ctl(), 6'b010000);
            end
            tick();
        end
        n_checks++;
        if (ctl() !== 6'b000011) begin
            n_fail++; $display("FAIL timeout_wb got=%b exp=%b", ctl(), 6'b000011);
        end
        tick();
        n_checks++;
        if (ctl() !== 6'b100000) begin
            n_fail++; $display("FAIL timeout_idle got=%b exp=%b", ctl(), 6'b100000);
        end
`else
        for (int c = 1; c <= 20; c++) begin
            n_checks++;
            if (ctl() !== 6'b010000) begin
                n_fail++; $display("FAIL wait_mem_c%0d got=%b exp=%b", c, ctl(), 6'b010000);
            end
            tick();
        end
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_0042;
        tick();
        bus.mem_ack = 1'b0;
        n_checks++;
        if (ctl() !== {3'b000, ex.rd != 4'd0, 2'b10}) begin
            n_fail++; $display("FAIL wait_wb got=%b exp_rfwe=%0d", ctl(), ex.rd != 4'd0);
        end
        tick();
`endif
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            execute_t    e     = rand_ex();
            logic [1:0]  k     = 2'($urandom_range(0, 3));
            int          dly   = $urandom_range(0, 2);
            int          gap   = $urandom_range(0, 2);
            logic [31:0] rdata = $urandom;
            logic        is_mem   = (k == 2'b01) || (k == 2'b10);
            logic        exp_we   = (k != 2'b10) && (e.rd != 4'd0);
            logic [31:0] exp_data = (k == 2'b01) ? rdata : e.x_rd;
            for (int g = 0; g < gap; g++) begin
                ex_valid = 1'b0; bus.mem_ack = 1'($urandom_range(0, 1));
                tick();
            end
            ex = e; ex_kind = k; ex_valid = 1'b1; bus.mem_ack = 1'b0;
            tick();
            ex_valid = 1'b0;
            if (is_mem) begin
                for (int c = 0; c <= dly; c++) begin
                    n_checks++;
                    if (ctl() !== {2'b01, k == 2'b10, 3'b000} || bus.mem_addr !== e.addr_4byte ||
                        (k == 2'b10 && bus.mem_wdata !== e.mem_val)) begin
                        n_fail++; $display("FAIL rnd%0d_mem got=%b/%h exp_kind=%0d exp_addr=%h",
                            t, ctl(), bus.mem_addr, k, e.addr_4byte);
                    end
                    if (c == dly) begin bus.mem_ack = 1'b1; bus.mem_rdata = rdata; end
                    tick();
                end
                bus.mem_ack = 1'b0; bus.mem_rdata = $urandom;
            end
            n_checks++;
            if (ctl() !== {3'b000, exp_we, 2'b10} || rf_wdata !== exp_data ||
                rf_waddr !== e.rd || pc_next !== e.pc) begin
                n_fail++; $display("FAIL rnd%0d_wb got=%b/%h/%h/%h exp_we=%0d exp=%h/%h/%h",
                    t, ctl(), rf_waddr, rf_wdata, pc_next, exp_we, e.rd, exp_data, e.pc);
            end
            tick();
        end
    endtask

    initial begin
        ex = '0; ex_kind = 2'b00; ex_valid = 1'b0; reset = 1'b1;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        test_reset();
        test_plain();
        test_load();
        test_store();
        test_x0();
        test_reset_mid_mem();
        test_ignore_ack();
        test_back_to_back();
        test_timeout();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_mem_wb.md
CPU_MEM_WB -- requirements
Module: cpu_mem_wb

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 8'd255, MEM-state cycles without mem_ack before abort (used only with CPU_MEM_TIMEOUT_EN).
REQ-002 Parameter: RD_W, default 4, register index width.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ex_valid  in  1  execute result offered.
REQ-006 ex_ready  out  1  stage can accept; handshake completes on ex_valid && ex_ready at clk edge.
REQ-007 ex  in  EXECUTE  execute-stage result (pc, rd, x_rd, addr_4byte, mem_val, intr_en).
REQ-008 ex_kind  in  2  00 plain, 01 load, 10 store, 11 reserved (treated as plain).
REQ-009 mem_req  out  1  data-bus request, held until mem_ack.
REQ-010 mem_we  out  1  1 = store, 0 = load; valid while mem_req.
REQ-011 mem_addr  out  30  word address (captured addr_4byte).
REQ-012 mem_wdata  out  32  store data (captured mem_val).
REQ-013 mem_ack  in  1  bus completion; sampled only while mem_req.
REQ-014 mem_rdata  in  32  load data; valid in the mem_ack cycle.
REQ-015 rf_we  out  1  register-file write strobe, one cycle.
REQ-016 rf_waddr  out  RD_W  destination register.
REQ-017 rf_wdata  out  32  write data.
REQ-018 pc_valid  out  1  one-cycle strobe: pc_next is committed.
REQ-019 pc_next  out  32  committed next PC (captured ex.pc).
REQ-020 err  out  1  one-cycle bus-timeout strobe; constant 0 without CPU_MEM_TIMEOUT_EN.

Function
REQ-021 FSM states IDLE, MEM, WB; encoding an enum in the shared package.
REQ-022 IDLE: ex_ready=1; on handshake capture ex and ex_kind; kind load/store -> MEM, else -> WB.
REQ-023 MEM and WB: ex_ready=0; no new transaction accepted.
REQ-024 MEM: mem_req=1, mem_we/mem_addr/mem_wdata stable from captured values until the ack cycle inclusive.
REQ-025 MEM: mem_ack=1 -> capture mem_rdata (load only) and go to WB; ack in the first MEM cycle is legal.
REQ-026 WB: exactly one cycle, then IDLE; pc_valid=1, pc_next=captured pc.
REQ-027 WB: rf_we=1 iff kind != store and rd != 0 and no timeout; x0 writes always suppressed.
REQ-028 rf_wdata = captured mem_rdata for load, captured x_rd otherwise; rf_waddr = captured rd.
REQ-029 Latency: plain op WB one cycle after handshake; memory op WB one cycle after the mem_ack cycle.
REQ-030 Back-to-back throughput: a new handshake may occur in the IDLE cycle immediately after WB (plain op every 2 cycles).
REQ-031 mem_ack outside MEM is ignored; ex_valid outside IDLE is not consumed.
REQ-032 All outputs are functions of registered state only (no ex_* -> output combinational path except ex_ready, itself state-only).

Reset
REQ-033 reset=1 at an edge forces IDLE and clears captured data and timeout counter, overriding any simultaneous handshake or mem_ack.
REQ-034 Outputs after reset: ex_ready=1; mem_req, mem_we, rf_we, pc_valid, err=0; mem_addr, mem_wdata, rf_waddr, rf_wdata, pc_next=0.
REQ-035 Reset mid-MEM drops the request with no WB; the bus is responsible for discarding the outstanding access.

Configuration
REQ-036 Macro CPU_MEM_TIMEOUT_EN defined: 8-bit counter cleared on MEM entry, increments each MEM cycle without ack; on reaching TIMEOUT_CYCLES -> WB with err=1, rf_we=0, pc_valid=1.
REQ-037 Macro undefined: no counter, MEM waits for mem_ack indefinitely, err tied 0.

Structure
REQ-038 Shared package lib_cpu holds EXECUTE, the ex_kind enum (KIND_PLAIN/LOAD/STORE) and the FSM state enum.
REQ-039 No sub-module; one always_ff for state/capture plus one always_comb for outputs.

Verification
REQ-040 Plain: ex.rd=3, x_rd=32'h1234_5678 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=32'h1234_5678, pc_valid=1.
REQ-041 Load: addr_4byte=30'h10, mem_ack after 3 cycles with mem_rdata=32'hDEAD_BEEF, rd=5 -> mem_req high 3 cycles, next cycle rf_we=1, rf_wdata=32'hDEAD_BEEF.
REQ-042 Store: mem_val=32'hA5A5_A5A5, ack in first MEM cycle -> mem_we=1, mem_wdata=32'hA5A5_A5A5, WB with rf_we=0, pc_valid=1.
REQ-043 Write to rd=0 with x_rd=32'hFFFF_FFFF -> rf_we=0, pc_valid=1.
REQ-044 Reset asserted in second MEM cycle with simultaneous mem_ack -> next cycle IDLE, mem_req=0, rf_we=0, pc_valid=0.
REQ-045 CPU_MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> mem_req high 4 cycles, then err=1, rf_we=0, pc_valid=1 for one cycle.
